// File: rtl/satatx_align_sched.sv
// SATA transmit scheduler: merges link-layer dwords with periodic ALIGN bursts,
// fills source gaps with SYNC and holds ALIGN while the PHY link is down.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_phy_ready             PHY link up; low forces continuous ALIGN
//   S_VALID/S_READY/S_DATA  link-layer source, {is_primitive, dword}
//   M_VALID/M_READY/M_DATA  registered stream to encoder, {k_flag, dword}
//   o_fill                  one-cycle pulse when a SYNC filler is loaded
//   o_align                 high while M_DATA holds a scheduled ALIGN
module satatx_align_sched #(
    parameter int ALIGN_INTERVAL = 256,
    parameter int ALIGN_COUNT    = 2,
    parameter int CW             = 9
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_phy_ready,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [32:0] S_DATA,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic [32:0] M_DATA,
    output logic        o_fill,
    output logic        o_align
);

    localparam logic [32:0] ALIGN_W = {1'b1, 32'h7B4A_4ABC};
    localparam logic [32:0] SYNC_W  = {1'b1, 32'hB5B5_957C};

    localparam int BW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(ALIGN_INTERVAL - 1);
    localparam logic [BW-1:0] LAST_BST = BW'(ALIGN_COUNT - 1);

    typedef enum logic [1:0] {
        ST_DOWN,
        ST_RUN,
        ST_ALIGN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bidx, bidx_n;

    logic          load;
    logic          burst_due;
    logic          valid_n;
    logic [32:0]   data_n;
    logic          align_n;
    logic          fill_n;

    // Output register takes a new word when empty or when the encoder accepts.
    assign load      = !M_VALID || M_READY;
    assign burst_due = (state == ST_ALIGN);

    // Source is only taken on a RUN load with the link up, so a word handed
    // over here always lands in M_DATA.
    assign S_READY = i_phy_ready && (state == ST_RUN) && !burst_due && load;

    // State register and output stage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_DOWN;
            cnt     <= '0;
            bidx    <= '0;
            M_VALID <= 1'b0;
            M_DATA  <= ALIGN_W;
            o_align <= 1'b0;
            o_fill  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bidx    <= bidx_n;
            M_VALID <= valid_n;
            M_DATA  <= data_n;
            o_align <= align_n;
            o_fill  <= fill_n;
        end
    end

    // Next-state logic; the counter advances on loads only and saturates
    // at the last slot of the interval.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bidx;
        if (!i_phy_ready) begin
            state_n = ST_DOWN;
            cnt_n   = '0;
            bidx_n  = '0;
        end else begin
            unique case (state)
                ST_DOWN: begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                    bidx_n  = '0;
                end
                ST_RUN: begin
                    if (load) begin
                        if (cnt == LAST_CNT) begin
                            state_n = ST_ALIGN;
                            bidx_n  = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                ST_ALIGN: begin
                    if (load) begin
                        if (bidx == LAST_BST) begin
                            state_n = ST_RUN;
                            cnt_n   = '0;
                            bidx_n  = '0;
                        end else begin
                            bidx_n = bidx + BW'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_DOWN;
                    cnt_n   = '0;
                    bidx_n  = '0;
                end
            endcase
        end
    end

    // Output-stage next values. A link drop overwrites even a stalled word,
    // so the encoder never sees stale payload after the PHY goes away.
    always_comb begin
        valid_n = M_VALID;
        data_n  = M_DATA;
        align_n = o_align;
        fill_n  = 1'b0;
        if (!i_phy_ready) begin
            valid_n = 1'b1;
            data_n  = ALIGN_W;
            align_n = 1'b0;
        end else if (load) begin
            valid_n = 1'b1;
            unique case (state)
                ST_DOWN: begin
                    data_n  = ALIGN_W;
                    align_n = 1'b0;
                end
                ST_RUN: begin
                    align_n = 1'b0;
                    if (S_VALID) begin
                        data_n = S_DATA;
                    end else begin
                        data_n = SYNC_W;
                        fill_n = 1'b1;
                    end
                end
                ST_ALIGN: begin
                    data_n  = ALIGN_W;
                    align_n = 1'b1;
                end
                default: begin
                    data_n  = ALIGN_W;
                    align_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_satatx_align_sched.sv
// Randomised bench for satatx_align_sched against a word-slot model of the
// ALIGN schedule, SYNC filling, link-down and reset behaviour.
module tb_satatx_align_sched;

    localparam logic [32:0] ALIGN_W = {1'b1, 32'h7B4A_4ABC};
    localparam logic [32:0] SYNC_W  = {1'b1, 32'hB5B5_957C};
    localparam int INTERVAL = 256;
    localparam int NBURST   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phy = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [32:0] s_data = 33'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [32:0] m_data;
    logic        fill;
    logic        align;

    always #5 clk = ~clk;

    satatx_align_sched dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_phy_ready (phy),
        .S_VALID     (s_valid),
        .S_READY     (s_ready),
        .S_DATA      (s_data),
        .M_VALID     (m_valid),
        .M_READY     (m_ready),
        .M_DATA      (m_data),
        .o_fill      (fill),
        .o_align     (align)
    );

    int total = 0;
    int bad   = 0;

    // Model: expected output word plus schedule position
    logic        e_valid = 1'b0;
    logic [32:0] e_data  = ALIGN_W;
    logic        e_align = 1'b0;
    logic        e_fill  = 1'b0;
    bit          up      = 1'b0;
    bit          known   = 1'b0;
    int          n       = 0;
    int          bl      = 0;
    logic [31:0] seq     = 32'd0;

    task automatic chk(input string tag, input logic [32:0] got,
                       input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_src();
        seq++;
        if ($urandom_range(0, 15) == 0) s_data = ALIGN_W;
        else s_data = {1'b0, seq};
    endtask

    // One clock: check S_READY, predict the edge, check registered outputs.
    task automatic step();
        bit ld;
        bit srdy;
        bit acc;
        #1;
        ld   = !e_valid || m_ready;
        srdy = phy && up && (bl == 0) && ld;
        if (known && !rst) chk("s_ready", {32'd0, s_ready}, {32'd0, srdy});
        acc    = 1'b0;
        e_fill = 1'b0;
        if (rst) begin
            e_valid = 1'b0;
            e_data  = ALIGN_W;
            e_align = 1'b0;
            up      = 1'b0;
            n       = 0;
            bl      = 0;
            known   = 1'b1;
        end else if (!phy) begin
            e_valid = 1'b1;
            e_data  = ALIGN_W;
            e_align = 1'b0;
            up      = 1'b0;
            n       = 0;
            bl      = 0;
        end else if (!up) begin
            if (ld) begin
                e_valid = 1'b1;
                e_data  = ALIGN_W;
                e_align = 1'b0;
            end
            up = 1'b1;
            n  = 0;
        end else if (ld) begin
            e_valid = 1'b1;
            if (bl > 0) begin
                e_data  = ALIGN_W;
                e_align = 1'b1;
                bl--;
                if (bl == 0) n = 0;
            end else begin
                e_align = 1'b0;
                if (s_valid) begin
                    e_data = s_data;
                    acc    = 1'b1;
                end else begin
                    e_data = SYNC_W;
                    e_fill = 1'b1;
                end
                n++;
                if (n == INTERVAL) bl = NBURST;
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", {32'd0, m_valid}, {32'd0, e_valid});
        chk("m_data", m_data, e_data);
        chk("o_align", {32'd0, align}, {32'd0, e_align});
        chk("o_fill", {32'd0, fill}, {32'd0, e_fill});
        if (acc) next_src();
    endtask

    // Run until the DUT shows a scheduled ALIGN, bounded.
    task automatic wait_burst();
        int k;
        k = 0;
        while (align !== 1'b1 && k < 600) begin
            step();
            k++;
        end
        chk("burst_wait", {32'd0, align}, 33'd1);
    endtask

    initial begin
        s_data = {1'b0, seq};
        // Reset and link-down ALIGN stream
        rst = 1'b1;
        phy = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();
        // Full-rate source, two intervals plus bursts
        phy = 1'b1;
        s_valid = 1'b1;
        repeat (600) step();
        // Encoder backpressure
        repeat (700) begin
            m_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        m_ready = 1'b1;
        // Source underflow
        s_valid = 1'b0;
        repeat (5) step();
        s_valid = 1'b1;
        repeat (600) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        // Link drop in the middle of a burst
        s_valid = 1'b1;
        m_ready = 1'b1;
        wait_burst();
        phy = 1'b0;
        repeat (3) step();
        phy = 1'b1;
        repeat (300) step();
        // Link drop while the output is stalled
        m_ready = 1'b0;
        repeat (2) step();
        phy = 1'b0;
        repeat (2) step();
        phy = 1'b1;
        m_ready = 1'b1;
        repeat (270) step();
        // Reset during a burst with the encoder stalled
        wait_burst();
        m_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (20) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
